mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage memory access controller. Sits between the EX/MEM pipeline register and the
//  block-RAM byte-write-enable adapter / BRAM IP core. Converts load/store requests of
//  byte/half/word size into a per-byte write-enable mask, lane-replicated store data and a
//  word address. Waits out the BRAM read latency with a pipeline stall. Extracts and
//  sign/zero-extends load data for the MEM/WB register.
// PARAMETERS
//  ADDR_W    10  BRAM word-address width; ram_addr = addr[ADDR_W+1:2]
//  READ_LAT  1   BRAM read latency in clocks (legal 1..3)
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       synchronous, active-high reset
//  mem_read      in   1       load request (EX/MEM)
//  mem_write     in   1       store request (EX/MEM)
//  mem_size      in   2       00 byte, 01 half, 10/11 word
//  mem_unsigned  in   1       1 = zero-extend load (LBU/LHU), 0 = sign-extend
//  addr          in   32      byte address
//  wdata         in   32      store data, right-justified
//  ram_addr      out  ADDR_W  BRAM word address
//  ram_we        out  4       per-byte write enable; bit i = bits [8i+7:8i]
//  ram_din       out  32      BRAM write data
//  ram_dout      in   32      BRAM read data, valid READ_LAT clocks after address
//  stall_out     out  1       freeze PC, IF/ID, ID/EX and EX/MEM this cycle
//  rdata_out     out  32      extended load data
//  rdata_valid   out  1       rdata_out valid this cycle (MEM/WB captures at edge)
//  misaligned    out  1       current request is misaligned; access suppressed
// BEHAVIOUR
//  - Endianness: little-endian. Byte lane = addr[1:0]. Lane 0 = ram bits [7:0].
//  - Alignment: half needs addr[0]=0; word needs addr[1:0]=00; byte always aligned.
//  - Misaligned (IDLE only): misaligned=1 combinationally, ram_we=0000, stall_out=0,
//    no read issued, rdata_valid=0. The instruction retires as a NOP.
//  - Priority: mem_read && mem_write -> treated as read; ram_we=0000.
//  - Stores are single cycle, combinational in IDLE, stall_out=0:
//    - byte: ram_we = 0001<<addr[1:0]; ram_din = {4{wdata[7:0]}}
//    - half: ram_we = addr[1] ? 1100 : 0011; ram_din = {2{wdata[15:0]}}
//    - word: ram_we = 1111; ram_din = wdata
//  - Idle outputs: ram_din=wdata and ram_we=0000 when no store.
//    ram_addr = addr[ADDR_W+1:2] in IDLE.
//  - FSM states: IDLE, WAIT, DONE. A down-counter cnt (2 bits) is used in WAIT.
//  - IDLE + aligned load: stall_out=1; latch addr[1:0], mem_size, mem_unsigned and word
//    address; cnt<=READ_LAT-1. Go to WAIT if READ_LAT>1, else DONE.
//  - WAIT: stall_out=1; ram_addr = latched word address; ram_we=0000; cnt decrements.
//    At cnt==1 go to DONE.
//  - DONE: stall_out=0; rdata_valid=1; rdata_out = extract(ram_dout) combinationally.
//    The same value is registered into rdata_hold. Go to IDLE.
//    DONE never accepts a new request (EX/MEM still holds the load).
//  - Extraction uses the latched lane:
//    - byte: ram_dout[8*lane+:8], extended to 32 bits
//    - half: ram_dout[16*lane[1]+:16], extended to 32 bits
//    - word: ram_dout
//  - Outside DONE: rdata_out = rdata_hold, rdata_valid=0.
//  - Load occupancy = READ_LAT+1 cycles; stall_out high for exactly READ_LAT cycles.
//  - Reset (any state, including mid-read): next cycle state=IDLE, cnt=0, rdata_hold=0.
//    Outputs rdata_out=0, rdata_valid=0, stall_out=0, ram_we=0000, misaligned=0.
//    An aborted load never pulses rdata_valid.
//  - misaligned and stall_out are never both 1. ram_we is always 0000 outside IDLE.
// TESTING
//  1. Reset held 2 cycles with mem_write=1 -> ram_we=0000, stall_out=0, rdata_valid=0,
//     rdata_out=0.
//  2. SB addr=0x6, wdata=0x123456AB -> ram_we=0100, ram_din=0xABABABAB, ram_addr=1,
//     stall_out=0. SH addr=0x2 -> ram_we=1100, ram_din=0x56AB56AB.
//  3. LB addr=0x3, BRAM word 0x80FF1234, READ_LAT=1 -> c0 stall=1; c1 stall=0,
//     rdata_valid=1, rdata_out=0xFFFFFF80. Same with LBU -> 0x00000080.
//  4. LH addr=0x2, word 0x80017FFF, READ_LAT=2 -> stall=1 for c0..c1; c2 rdata_valid=1,
//     rdata_out=0xFFFF8001. LW addr=0x0 -> 0x80017FFF.
//  5. SW addr=0x5 -> misaligned=1, ram_we=0000, stall_out=0. LH addr=0x1 -> misaligned=1,
//     no stall, no rdata_valid.
//  6. mem_read=mem_write=1 -> read path, ram_we=0000. Reset asserted in WAIT
//     (READ_LAT=3) -> next cycle IDLE, stall_out=0, rdata_valid never 1.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: builds byte enables and replicated store data for the BRAM,
// stalls the pipeline across the BRAM read latency and extends load data for MEM/WB.
//
// state | meaning
// IDLE  | accept request; stores complete here, loads launch the read
// WAIT  | read in flight, counting down remaining latency
// DONE  | BRAM data valid; extract, extend and present to MEM/WB
module mem_access_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic              stall_out,
    output logic [31:0]       rdata_out,
    output logic              rdata_valid,
    output logic              misaligned
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_cnt, w_cnt_nxt;
    logic [1:0]          r_lane, w_lane_nxt;
    logic [1:0]          r_size, w_size_nxt;
    logic                r_uns, w_uns_nxt;
    logic [ADDR_W-1:0]   r_waddr, w_waddr_nxt;
    logic [31:0]         r_hold, w_hold_nxt;

    logic                w_misal;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_ext;
    logic                w_unused_addr;

    assign w_unused_addr = ^addr[31:ADDR_W+2];

    assign w_misal = (mem_read || mem_write) &&
                     (((mem_size == 2'b01) && addr[0]) ||
                      (mem_size[1] && (addr[1:0] != 2'b00)));

    // Extraction always uses the lane/size latched when the load was launched.
    assign w_byte = ram_dout[{r_lane, 3'b000} +: 8];
    assign w_half = ram_dout[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = ram_dout;
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_ext = ram_dout;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lane_nxt  = r_lane;
        w_size_nxt  = r_size;
        w_uns_nxt   = r_uns;
        w_waddr_nxt = r_waddr;
        w_hold_nxt  = r_hold;
        ram_addr    = addr[ADDR_W+1:2];
        ram_we      = 4'b0000;
        ram_din     = wdata;
        stall_out   = 1'b0;
        rdata_out   = r_hold;
        rdata_valid = 1'b0;
        misaligned  = 1'b0;

        case (r_state)
            S_IDLE: begin
                misaligned = w_misal;
                if (!w_misal) begin
                    if (mem_read) begin
                        stall_out   = 1'b1;
                        w_lane_nxt  = addr[1:0];
                        w_size_nxt  = mem_size;
                        w_uns_nxt   = mem_unsigned;
                        w_waddr_nxt = addr[ADDR_W+1:2];
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = (READ_LAT > 1) ? S_WAIT : S_DONE;
                    end else if (mem_write) begin
                        case (mem_size)
                            2'b00: begin
                                ram_we  = 4'b0001 << addr[1:0];
                                ram_din = {4{wdata[7:0]}};
                            end
                            2'b01: begin
                                ram_we  = addr[1] ? 4'b1100 : 4'b0011;
                                ram_din = {2{wdata[15:0]}};
                            end
                            default: begin
                                ram_we  = 4'b1111;
                                ram_din = wdata;
                            end
                        endcase
                    end
                end
            end
            S_WAIT: begin
                ram_addr  = r_waddr;
                stall_out = 1'b1;
                w_cnt_nxt = r_cnt - 2'd1;
                if (r_cnt <= 2'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ram_addr    = r_waddr;
                rdata_valid = 1'b1;
                rdata_out   = w_ext;
                w_hold_nxt  = w_ext;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Reset is synchronous, so mask outputs during the reset cycle itself.
        if (reset) begin
            ram_we      = 4'b0000;
            stall_out   = 1'b0;
            misaligned  = 1'b0;
            rdata_valid = 1'b0;
            rdata_out   = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_lane  <= 2'd0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_waddr <= '0;
            r_hold  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lane  <= w_lane_nxt;
            r_size  <= w_size_nxt;
            r_uns   <= w_uns_nxt;
            r_waddr <= w_waddr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

endmodule
